// File: rtl/rf_commit_arbiter.sv
// rf_commit_arbiter: merges the two in-order RoB commit lanes onto the single
// register-file update port through a small FIFO. Write order is preserved.
// A flush is held back until every committed write has been retired.
// Optional build macro: RF_COMMIT_BYPASS_EN. When defined, a single write
// accepted into an empty FIFO in RUN goes straight to the update port in the
// same cycle.
module rf_commit_arbiter #(
  parameter int unsigned RoB_WIDTH = 3,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 c0_valid,
  input  logic [4:0]           c0_reg,
  input  logic [RoB_WIDTH-1:0] c0_index,
  input  logic [31:0]          c0_data,
  input  logic                 c1_valid,
  input  logic [4:0]           c1_reg,
  input  logic [RoB_WIDTH-1:0] c1_index,
  input  logic [31:0]          c1_data,
  output logic                 c0_ready,
  output logic                 c1_ready,
  input  logic                 flush_in,
  output logic                 upd_en,
  output logic [4:0]           upd_reg,
  output logic [RoB_WIDTH-1:0] upd_index,
  output logic [31:0]          upd_data,
  output logic                 flush_out,
  output logic                 busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]           rd;
    logic [RoB_WIDTH-1:0] idx;
    logic [31:0]          data;
  } entry_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];

  logic [CW-1:0]   free;
  logic            run_ok;
  logic            acc0, acc1;
  logic            wr0, wr1;
  logic            byp0, byp1;
  logic            push0, push1;
  logic            pop;
  logic [PW-1:0]   slot1;
  entry_t          ent0, ent1, head;
`ifdef RF_COMMIT_BYPASS_EN
  logic            byp_ok;
`endif

  // Lane acceptance from the free space seen at the start of the cycle
  always_comb begin
    ent0     = '{rd: c0_reg, idx: c0_index, data: c0_data};
    ent1     = '{rd: c1_reg, idx: c1_index, data: c1_data};
    free     = DEPTH_C - count_q;
    run_ok   = rdy_in && (state_q == ST_RUN);
    c0_ready = run_ok && (free >= CW'(1));
    // lane 1 may only use the last slot when lane 0 is not competing for it
    c1_ready = run_ok && ((free >= CW'(2)) || (!c0_valid && (free >= CW'(1))));
    acc0     = c0_valid && c0_ready;
    acc1     = c1_valid && c1_ready;
    // x0 writes are acknowledged but never occupy a slot
    wr0      = acc0 && (c0_reg != '0);
    wr1      = acc1 && (c1_reg != '0);
    pop      = rdy_in && (count_q != '0);
`ifdef RF_COMMIT_BYPASS_EN
    byp_ok   = run_ok && (count_q == '0);
    byp0     = byp_ok && wr0;
    byp1     = byp_ok && wr1 && !wr0;
`else
    byp0     = 1'b0;
    byp1     = 1'b0;
`endif
    push0    = wr0 && !byp0;
    push1    = wr1 && !byp1;
  end

  // FIFO next state: up to two pushes in lane order, one pop from the head
  always_comb begin
    mem_d    = mem_q;
    slot1    = push0 ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    if (push0) begin
      mem_d[wr_ptr_q] = ent0;
    end
    if (push1) begin
      mem_d[slot1] = ent1;
    end
    wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Update port: FIFO head first, otherwise a bypassed write, otherwise idle zeros
  always_comb begin
    head      = mem_q[rd_ptr_q];
    upd_en    = 1'b0;
    upd_reg   = '0;
    upd_index = '0;
    upd_data  = '0;
    if (pop) begin
      upd_en    = 1'b1;
      upd_reg   = head.rd;
      upd_index = head.idx;
      upd_data  = head.data;
    end else if (byp0) begin
      upd_en    = 1'b1;
      upd_reg   = ent0.rd;
      upd_index = ent0.idx;
      upd_data  = ent0.data;
    end else if (byp1) begin
      upd_en    = 1'b1;
      upd_reg   = ent1.rd;
      upd_index = ent1.idx;
      upd_data  = ent1.data;
    end
  end

  // Flush sequencing: drain the FIFO to empty, then one flush_out cycle
  always_comb begin
    state_d   = state_q;
    flush_out = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        ST_RUN: begin
          // writes accepted alongside the flush are counted in count_d
          if (flush_in) begin
            state_d = (count_d == '0) ? ST_FLUSH : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (count_d == '0) begin
            state_d = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_out = 1'b1;
          state_d   = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
    busy = (count_q != '0) || (state_q != ST_RUN);
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through count-qualified reads
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_rf_commit_arbiter.sv
`timescale 1ns/1ps
module tb_rf_commit_arbiter;

  localparam int unsigned RW    = 3;
  localparam int unsigned DEPTH = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, flush_in;
  logic          c0_valid, c1_valid;
  logic [4:0]    c0_reg, c1_reg;
  logic [RW-1:0] c0_index, c1_index;
  logic [31:0]   c0_data, c1_data;
  logic          c0_ready, c1_ready, upd_en, flush_out, busy;
  logic [4:0]    upd_reg;
  logic [RW-1:0] upd_index;
  logic [31:0]   upd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  rf_commit_arbiter #(.RoB_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .c0_valid(c0_valid), .c0_reg(c0_reg), .c0_index(c0_index), .c0_data(c0_data),
    .c1_valid(c1_valid), .c1_reg(c1_reg), .c1_index(c1_index), .c1_data(c1_data),
    .c0_ready(c0_ready), .c1_ready(c1_ready), .flush_in(flush_in),
    .upd_en(upd_en), .upd_reg(upd_reg), .upd_index(upd_index), .upd_data(upd_data),
    .flush_out(flush_out), .busy(busy)
  );

  typedef struct {
    logic [4:0]    r;
    logic [RW-1:0] i;
    logic [31:0]   d;
  } wr_t;

  // Reference model: queue of committed-but-not-retired writes plus a phase
  wr_t mq[$];
  int  mphase;  // 0 normal, 1 waiting for queue to empty, 2 flush strobe
  int  cyc = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance the model
  task automatic model_cycle();
    bit   run, pop, e_r0, e_r1, e_en, e_fl, e_busy;
    int   free;
    wr_t  e, acc[$];
    run  = rdy_in && (mphase == 0);
    free = int'(DEPTH) - mq.size();
    e_r0 = run && (free >= 1);
    e_r1 = run && ((free >= 2) || (!c0_valid && free >= 1));
    pop  = rdy_in && (mq.size() > 0);
    e_en = 1'b0;
    e    = '{r: 5'd0, i: '0, d: 32'd0};
    if (pop) begin
      e_en = 1'b1;
      e    = mq[0];
    end
    if (c0_valid && e_r0 && c0_reg != 5'd0) acc.push_back('{r: c0_reg, i: c0_index, d: c0_data});
    if (c1_valid && e_r1 && c1_reg != 5'd0) acc.push_back('{r: c1_reg, i: c1_index, d: c1_data});
`ifdef RF_COMMIT_BYPASS_EN
    if (run && mq.size() == 0 && acc.size() > 0) begin
      e_en = 1'b1;
      e    = acc.pop_front();
    end
`endif
    e_fl   = rdy_in && (mphase == 2);
    e_busy = (mq.size() != 0) || (mphase != 0);
    chk1($sformatf("c%0d c0_ready", cyc), c0_ready, e_r0);
    chk1($sformatf("c%0d c1_ready", cyc), c1_ready, e_r1);
    chk1($sformatf("c%0d upd_en", cyc), upd_en, e_en);
    chk32($sformatf("c%0d upd_reg", cyc), 32'(upd_reg), 32'(e.r));
    chk32($sformatf("c%0d upd_index", cyc), 32'(upd_index), 32'(e.i));
    chk32($sformatf("c%0d upd_data", cyc), upd_data, e.d);
    chk1($sformatf("c%0d flush_out", cyc), flush_out, e_fl);
    chk1($sformatf("c%0d busy", cyc), busy, e_busy);
    if (rdy_in) begin
      if (pop) void'(mq.pop_front());
      foreach (acc[k]) mq.push_back(acc[k]);
      case (mphase)
        0: if (flush_in) mphase = (mq.size() == 0) ? 2 : 1;
        1: if (mq.size() == 0) mphase = 2;
        default: mphase = 0;
      endcase
    end
    cyc++;
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    c0_valid = 1'b0; c0_reg = 5'd0; c0_index = '0; c0_data = 32'd0;
    c1_valid = 1'b0; c1_reg = 5'd0; c1_index = '0; c1_data = 32'd0;
  endtask

  task automatic cycle();
    #3;
    model_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b0;
    #3;
    chk1("rst c0_ready", c0_ready, 1'b1);
    chk1("rst c1_ready", c1_ready, 1'b1);
    chk1("rst upd_en", upd_en, 1'b0);
    chk32("rst upd_data", upd_data, 32'd0);
    chk1("rst flush_out", flush_out, 1'b0);
    chk1("rst busy", busy, 1'b0);
    mq.delete();
    mphase = 0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    bit c0v; logic [4:0] c0r; logic [RW-1:0] c0i; logic [31:0] c0d;
    bit c1v; logic [4:0] c1r; logic [RW-1:0] c1i; logic [31:0] c1d;
    bit fl; bit rd;
    bit en; logic [4:0] er; logic [RW-1:0] ei; logic [31:0] ed;
    bit efl; bit r0; bit r1;
  } vec_t;

  function automatic vec_t mk(
      bit c0v, logic [4:0] c0r, logic [RW-1:0] c0i, logic [31:0] c0d,
      bit c1v, logic [4:0] c1r, logic [RW-1:0] c1i, logic [31:0] c1d,
      bit fl, bit rd, bit en, logic [4:0] er, logic [RW-1:0] ei, logic [31:0] ed,
      bit efl, bit r0, bit r1);
    vec_t v;
    v.c0v = c0v; v.c0r = c0r; v.c0i = c0i; v.c0d = c0d;
    v.c1v = c1v; v.c1r = c1r; v.c1i = c1i; v.c1d = c1d;
    v.fl = fl; v.rd = rd; v.en = en; v.er = er; v.ei = ei; v.ed = ed;
    v.efl = efl; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    idle();
    rst_in = 1'b0;
    mphase = 0;
    #2;
    do_reset();

    // columns: lane0 {v,reg,idx,data} lane1 {v,reg,idx,data} flush rdy | en reg idx data flush_out c0r c1r
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd5, 3'd2, 32'hDEADBEEF, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 3'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd0, 3'd1, 32'h11, 1'b1, 5'd7, 3'd3, 32'h77, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd7, 3'd3, 32'h77, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd1, 3'd0, 32'h100, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd2, 3'd1, 32'h200, 1'b1, 5'd3, 3'd2, 32'h300, 1'b1, 1'b1, 1'b1, 5'd1, 3'd0, 32'h100, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd9, 3'd7, 32'h999, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd2, 3'd1, 32'h200, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd3, 3'd2, 32'h300, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'd4, 3'd3, 32'h400, 1'b1, 5'd5, 3'd4, 32'h500, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'd6, 3'd5, 32'h600, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 3'd3, 32'h400, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 3'd4, 32'h500, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd8, 3'd0, 32'h8, 1'b1, 5'd9, 3'd1, 32'h9, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd10, 3'd2, 32'hA, 1'b1, 5'd11, 3'd3, 32'hB, 1'b0, 1'b1, 1'b1, 5'd8, 3'd0, 32'h8, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 5'd12, 3'd4, 32'hC, 1'b1, 5'd13, 3'd5, 32'hD, 1'b0, 1'b1, 1'b1, 5'd9, 3'd1, 32'h9, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'd13, 3'd5, 32'hD, 1'b1, 5'd14, 3'd6, 32'hE, 1'b0, 1'b1, 1'b1, 5'd10, 3'd2, 32'hA, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'd14, 3'd6, 32'hE, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd11, 3'd3, 32'hB, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12, 3'd4, 32'hC, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd13, 3'd5, 32'hD, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd14, 3'd6, 32'hE, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b1));

    // Directed table: fixed expectations for the FIFO-latency build, model in both
    for (int i = 0; i < tbl.size(); i++) begin
      c0_valid = tbl[i].c0v; c0_reg = tbl[i].c0r; c0_index = tbl[i].c0i; c0_data = tbl[i].c0d;
      c1_valid = tbl[i].c1v; c1_reg = tbl[i].c1r; c1_index = tbl[i].c1i; c1_data = tbl[i].c1d;
      flush_in = tbl[i].fl;  rdy_in = tbl[i].rd;
      #3;
`ifndef RF_COMMIT_BYPASS_EN
      chk1($sformatf("t%0d upd_en", i), upd_en, tbl[i].en);
      chk32($sformatf("t%0d upd_reg", i), 32'(upd_reg), 32'(tbl[i].er));
      chk32($sformatf("t%0d upd_index", i), 32'(upd_index), 32'(tbl[i].ei));
      chk32($sformatf("t%0d upd_data", i), upd_data, tbl[i].ed);
      chk1($sformatf("t%0d flush_out", i), flush_out, tbl[i].efl);
      chk1($sformatf("t%0d c0_ready", i), c0_ready, tbl[i].r0);
      chk1($sformatf("t%0d c1_ready", i), c1_ready, tbl[i].r1);
`endif
      model_cycle();
      @(posedge clk_in);
      #1;
    end

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 15) == 0);
      c0_valid = ($urandom_range(0, 3) != 0);
      c0_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      c0_index = RW'($urandom);
      c0_data  = $urandom;
      c1_valid = ($urandom_range(0, 3) != 0);
      c1_reg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      c1_index = RW'($urandom);
      c1_data  = $urandom;
      cycle();
    end

    // Reset asserted while draining discards buffered writes
    do_reset();
    idle();
    c0_valid = 1'b1; c0_reg = 5'd20; c0_index = 3'd1; c0_data = 32'hA0;
    c1_valid = 1'b1; c1_reg = 5'd21; c1_index = 3'd2; c1_data = 32'hA1;
    cycle();
    c0_reg = 5'd22; c0_index = 3'd3; c0_data = 32'hA2;
    c1_reg = 5'd23; c1_index = 3'd4; c1_data = 32'hA3;
    flush_in = 1'b1;
    cycle();
    idle();
    chk1("drain busy", busy, 1'b1);
    chk1("drain c0_ready", c0_ready, 1'b0);
    #1 rst_in = 1'b0;
    #1;
    chk1("midrst upd_en", upd_en, 1'b0);
    chk32("midrst upd_data", upd_data, 32'd0);
    chk1("midrst flush_out", flush_out, 1'b0);
    chk1("midrst c0_ready", c0_ready, 1'b1);
    chk1("midrst c1_ready", c1_ready, 1'b1);
    chk1("midrst busy", busy, 1'b0);
    mq.delete();
    mphase = 0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
